// File: rtl/game_pkg.sv
// Shared types and helpers for the rock/scissors/paper game controller.
package game_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'd0,
    SCISSORS = 2'd1,
    PAPER    = 2'd2,
    NONE     = 2'd3
  } hand_t;

  typedef enum logic [1:0] {
    SELECT    = 2'd0,
    WAIT_TICK = 2'd1,
    REVEAL    = 2'd2
  } state_t;

  localparam logic [1:0] SCORE_IDLE  = 2'b00;
  localparam logic [1:0] SCORE_LEFT  = 2'b10;
  localparam logic [1:0] SCORE_RIGHT = 2'b11;

  // A press is usable only when exactly one of the three key bits is set.
  function automatic logic key_valid(input logic [2:0] k);
    return (k == 3'b001) || (k == 3'b010) || (k == 3'b100);
  endfunction

  function automatic hand_t key_hand(input logic [2:0] k);
    case (k)
      3'b001:  return ROCK;
      3'b010:  return SCISSORS;
      3'b100:  return PAPER;
      default: return NONE;
    endcase
  endfunction

  // The hand that h defeats.
  function automatic hand_t beats(input hand_t h);
    case (h)
      ROCK:     return SCISSORS;
      SCISSORS: return PAPER;
      PAPER:    return ROCK;
      default:  return NONE;
    endcase
  endfunction

  // An absent hand (NONE) loses to any real hand.
  function automatic logic [1:0] judge(input hand_t l, input hand_t r);
    if (l == r)                     return SCORE_IDLE;
    else if (r == NONE)             return SCORE_LEFT;
    else if (l == NONE)             return SCORE_RIGHT;
    else if (beats(l) == r)         return SCORE_LEFT;
    else if (beats(r) == l)         return SCORE_RIGHT;
    else                            return SCORE_IDLE;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Registered rising-edge detector on vsync; produces a one-cycle frame tick.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vs_in,
  output logic tick
);

  logic vs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      tick <= 1'b0;
    end else begin
      vs_q <= vs_in;
      tick <= vs_in & ~vs_q;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Two-player rock/scissors/paper round controller with frame-synchronous outputs.
// Optional select timeout enabled by defining GAME_CTRL_TIMEOUT_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned REVEAL_FRAMES  = 120,
  parameter int unsigned TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs_in,
  input  logic [2:0] key_l,
  input  logic [2:0] key_r,
  output logic       show,
  output logic [3:0] hand,
  output logic [1:0] score
);

  localparam int unsigned RF_EFF = (REVEAL_FRAMES == 0) ? 1 : REVEAL_FRAMES;
  localparam int unsigned RC_W   = $clog2(RF_EFF + 1);
`ifdef GAME_CTRL_TIMEOUT_EN
  localparam int unsigned TO_EFF = (TIMEOUT_FRAMES == 0) ? 1 : TIMEOUT_FRAMES;
  localparam int unsigned TO_W   = $clog2(TO_EFF + 1);
`endif

  logic tick;

  state_t          state_q, state_d;
  logic            lock_l_q, lock_l_d, lock_r_q, lock_r_d;
  hand_t           hand_l_q, hand_l_d, hand_r_q, hand_r_d;
  logic [RC_W-1:0] rev_cnt_q, rev_cnt_d;
  logic            show_d;
  logic [3:0]      hand_d;
  logic [1:0]      score_d;
`ifdef GAME_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  frame_tick u_frame_tick (
    .clk   (clk),
    .rst   (rst),
    .vs_in (vs_in),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SELECT;
      lock_l_q  <= 1'b0;
      lock_r_q  <= 1'b0;
      hand_l_q  <= NONE;
      hand_r_q  <= NONE;
      rev_cnt_q <= '0;
      show      <= 1'b0;
      hand      <= 4'hF;
      score     <= SCORE_IDLE;
`ifdef GAME_CTRL_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lock_l_q  <= lock_l_d;
      lock_r_q  <= lock_r_d;
      hand_l_q  <= hand_l_d;
      hand_r_q  <= hand_r_d;
      rev_cnt_q <= rev_cnt_d;
`ifdef GAME_CTRL_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
      // Screen only refreshes on a frame boundary.
      if (tick) begin
        show  <= show_d;
        hand  <= hand_d;
        score <= score_d;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_l_d  = lock_l_q;
    lock_r_d  = lock_r_q;
    hand_l_d  = hand_l_q;
    hand_r_d  = hand_r_q;
    rev_cnt_d = rev_cnt_q;
`ifdef GAME_CTRL_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif

    case (state_q)
      SELECT: begin
        if (!lock_l_q && key_valid(key_l)) begin
          lock_l_d = 1'b1;
          hand_l_d = key_hand(key_l);
        end
        if (!lock_r_q && key_valid(key_r)) begin
          lock_r_d = 1'b1;
          hand_r_d = key_hand(key_r);
        end
        if (lock_l_q && lock_r_q) begin
          state_d = WAIT_TICK;
        end
`ifdef GAME_CTRL_TIMEOUT_EN
        // A timeout forfeits the absent player; a late press in that cycle loses.
        if (lock_l_q ^ lock_r_q) begin
          if (tick) begin
            if (to_cnt_q == TO_W'(TO_EFF - 1)) begin
              state_d   = REVEAL;
              to_cnt_d  = '0;
              rev_cnt_d = '0;
              if (!lock_l_q) begin
                lock_l_d = 1'b0;
                hand_l_d = NONE;
              end else begin
                lock_r_d = 1'b0;
                hand_r_d = NONE;
              end
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
        end else begin
          to_cnt_d = '0;
        end
`endif
      end

      WAIT_TICK: begin
        if (tick) begin
          state_d   = REVEAL;
          rev_cnt_d = '0;
        end
      end

      REVEAL: begin
        if (tick) begin
          if (rev_cnt_q == RC_W'(RF_EFF - 1)) begin
            state_d   = SELECT;
            rev_cnt_d = '0;
            lock_l_d  = 1'b0;
            lock_r_d  = 1'b0;
            hand_l_d  = NONE;
            hand_r_d  = NONE;
          end else begin
            rev_cnt_d = rev_cnt_q + RC_W'(1);
          end
        end
      end

      default: state_d = SELECT;
    endcase

    // Screen contents derived from the post-transition state, loaded on the tick.
    if (state_d == REVEAL) begin
      show_d  = 1'b1;
      hand_d  = {hand_r_d, hand_l_d};
      score_d = judge(hand_l_d, hand_r_d);
    end else begin
      show_d  = 1'b0;
      hand_d  = {(lock_r_d ? 2'b00 : 2'b11), (lock_l_d ? 2'b00 : 2'b11)};
      score_d = SCORE_IDLE;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl (REVEAL_FRAMES=120, TIMEOUT_FRAMES=3).
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs_in;
  logic [2:0] key_l;
  logic [2:0] key_r;
  logic       show;
  logic [3:0] hand;
  logic [1:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .REVEAL_FRAMES  (120),
    .TIMEOUT_FRAMES (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .vs_in (vs_in),
    .key_l (key_l),
    .key_r (key_r),
    .show  (show),
    .hand  (hand),
    .score (score)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One vsync rising edge; outputs settle by the end of this task.
  task automatic frame();
    vs_in = 1'b1;
    step();
    vs_in = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press(input logic [2:0] l, input logic [2:0] r);
    key_l = l;
    key_r = r;
    step();
    key_l = 3'b000;
    key_r = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL reset: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_left_wins();
    press(3'b001, 3'b010);
    step(2);
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL left_wins_pre_tick: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_0100_10) begin
      n_bad++;
      $display("FAIL left_wins_reveal: got show=%b hand=%b score=%b, want 1 0100 10", show, hand, score);
    end
    press(3'b100, 3'b100);
    frames(119);
    n_cmp++;
    if ({show, hand, score} !== 7'b1_0100_10) begin
      n_bad++;
      $display("FAIL left_wins_hold119: got show=%b hand=%b score=%b, want 1 0100 10", show, hand, score);
    end
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL left_wins_return: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
    // Press made during REVEAL must not have latched anything.
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL reveal_press_ignored: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
  endtask

  task automatic test_draw();
    press(3'b100, 3'b100);
    step(2);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_1010_00) begin
      n_bad++;
      $display("FAIL draw_reveal: got show=%b hand=%b score=%b, want 1 1010 00", show, hand, score);
    end
    frames(120);
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL draw_return: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
  endtask

  task automatic test_relock();
    press(3'b001, 3'b000);
    press(3'b100, 3'b000);
    press(3'b000, 3'b001);
    step(2);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_0000_00) begin
      n_bad++;
      $display("FAIL relock_reveal: got show=%b hand=%b score=%b, want 1 0000 00", show, hand, score);
    end
    frames(120);
  endtask

  task automatic test_invalid_key();
    press(3'b011, 3'b000);
    press(3'b111, 3'b010);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b0_0011_00) begin
      n_bad++;
      $display("FAIL invalid_placeholder: got show=%b hand=%b score=%b, want 0 0011 00", show, hand, score);
    end
    press(3'b010, 3'b000);
    step(2);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_0101_00) begin
      n_bad++;
      $display("FAIL invalid_then_valid: got show=%b hand=%b score=%b, want 1 0101 00", show, hand, score);
    end
    frames(120);
  endtask

  task automatic test_reset_mid_round();
    press(3'b100, 3'b001);
    step(2);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_0010_10) begin
      n_bad++;
      $display("FAIL paper_rock_reveal: got show=%b hand=%b score=%b, want 1 0010 10", show, hand, score);
    end
    frames(5);
    rst = 1'b1;
    step();
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL reset_in_reveal: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
    rst = 1'b0;
    press(3'b010, 3'b001);
    step(2);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_0001_11) begin
      n_bad++;
      $display("FAIL post_reset_round: got show=%b hand=%b score=%b, want 1 0001 11", show, hand, score);
    end
    frames(120);
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL post_reset_return: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
  endtask

  task automatic test_back_to_back();
    press(3'b001, 3'b100);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_1000_11) begin
      n_bad++;
      $display("FAIL b2b_first: got show=%b hand=%b score=%b, want 1 1000 11", show, hand, score);
    end
    frames(120);
    press(3'b010, 3'b100);
    frame();
    n_cmp++;
    if ({show, hand, score} !== 7'b1_1001_10) begin
      n_bad++;
      $display("FAIL b2b_second: got show=%b hand=%b score=%b, want 1 1001 10", show, hand, score);
    end
    frames(120);
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    step();
    rst = 1'b0;
    press(3'b000, 3'b100);
    frames(2);
    n_cmp++;
    if ({show, hand, score} !== 7'b0_0011_00) begin
      n_bad++;
      $display("FAIL timeout_waiting: got show=%b hand=%b score=%b, want 0 0011 00", show, hand, score);
    end
    frame();
`ifdef GAME_CTRL_TIMEOUT_EN
    n_cmp++;
    if ({show, hand, score} !== 7'b1_1011_11) begin
      n_bad++;
      $display("FAIL timeout_reveal: got show=%b hand=%b score=%b, want 1 1011 11", show, hand, score);
    end
    frames(120);
    n_cmp++;
    if ({show, hand, score} !== 7'b0_1111_00) begin
      n_bad++;
      $display("FAIL timeout_return: got show=%b hand=%b score=%b, want 0 1111 00", show, hand, score);
    end
`else
    frames(10);
    n_cmp++;
    if ({show, hand, score} !== 7'b0_0011_00) begin
      n_bad++;
      $display("FAIL no_timeout_wait: got show=%b hand=%b score=%b, want 0 0011 00", show, hand, score);
    end
`endif
  endtask

  initial begin
    rst   = 1'b1;
    vs_in = 1'b0;
    key_l = 3'b000;
    key_r = 3'b000;
    test_reset();
    test_left_wins();
    test_draw();
    test_relock();
    test_invalid_key();
    test_reset_mid_round();
    test_back_to_back();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
